// File: rtl/dmem_arbiter_if.sv
// Bundle of both master command/response ports plus the RAM-side signals of dmem_arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              m0_req;
    logic              m1_req;
    logic [3:0]        m0_we;
    logic [3:0]        m1_we;
    logic [3:0]        m0_re;
    logic [3:0]        m1_re;
    logic [ADDR_W-1:0] m0_addr;
    logic [ADDR_W-1:0] m1_addr;
    logic [31:0]       m0_wdata;
    logic [31:0]       m1_wdata;
    logic              m0_ack;
    logic              m1_ack;
    logic [31:0]       m0_rdata;
    logic [31:0]       m1_rdata;
    logic [3:0]        ram_we;
    logic [3:0]        ram_re;
    logic [ADDR_W-1:0] ram_w_addr;
    logic [ADDR_W-1:0] ram_r_addr;
    logic [31:0]       ram_w_data;
    logic [31:0]       ram_r_data;
    logic              busy;

    // Arbiter side.
    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_re, m1_re,
        input  m0_addr, m1_addr, m0_wdata, m1_wdata,
        output m0_ack, m1_ack, m0_rdata, m1_rdata,
        output ram_we, ram_re, ram_w_addr, ram_r_addr, ram_w_data,
        input  ram_r_data,
        output busy
    );

    // Requester side (both masters).
    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_re, m1_re,
        output m0_addr, m1_addr, m0_wdata, m1_wdata,
        input  m0_ack, m1_ack, m0_rdata, m1_rdata, busy
    );

    modport ram (
        input  ram_we, ram_re, ram_w_addr, ram_r_addr, ram_w_data,
        output ram_r_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master req/ack arbiter sequencing single-cycle data RAM accesses (IDLE->ACCESS->RESP).
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed priority to port 0.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 16
) (
    input logic            clk,
    input logic            rst,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [3:0]        cmd_we_q, cmd_we_d;
    logic [3:0]        cmd_re_q, cmd_re_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [31:0]       cmd_wdata_q, cmd_wdata_d;
    logic [31:0]       rdata0_q, rdata0_d;
    logic [31:0]       rdata1_q, rdata1_d;
    logic              grant;

    // Port index that wins when at least one req is high.
    always_comb begin
`ifdef DMEM_ARB_RR_EN
        if (bus.m0_req && bus.m1_req) begin
            grant = ~last_grant_q;
        end else begin
            grant = bus.m1_req;
        end
`else
        grant = ~bus.m0_req;
`endif
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cmd_we_d     = cmd_we_q;
        cmd_re_d     = cmd_re_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        case (state_q)
            StIdle: begin
                if (bus.m0_req || bus.m1_req) begin
                    state_d      = StAccess;
                    owner_d      = grant;
                    last_grant_d = grant;
                    cmd_we_d     = grant ? bus.m1_we    : bus.m0_we;
                    cmd_re_d     = grant ? bus.m1_re    : bus.m0_re;
                    cmd_addr_d   = grant ? bus.m1_addr  : bus.m0_addr;
                    cmd_wdata_d  = grant ? bus.m1_wdata : bus.m0_wdata;
                end
            end
            StAccess: begin
                state_d = StResp;
                if (cmd_re_q != 4'b0000) begin
                    if (owner_q) begin
                        rdata1_d = bus.ram_r_data;
                    end else begin
                        rdata0_d = bus.ram_r_data;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cmd_we_q     <= '0;
            cmd_re_q     <= '0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cmd_we_q     <= cmd_we_d;
            cmd_re_q     <= cmd_re_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Enables decode straight from state so an async reset kills a pending negedge write.
    assign bus.ram_we     = (state_q == StAccess) ? cmd_we_q : 4'b0000;
    assign bus.ram_re     = (state_q == StAccess) ? cmd_re_q : 4'b0000;
    assign bus.ram_w_addr = cmd_addr_q;
    assign bus.ram_r_addr = cmd_addr_q;
    assign bus.ram_w_data = cmd_wdata_q;
    assign bus.m0_ack     = (state_q == StResp) && !owner_q;
    assign bus.m1_ack     = (state_q == StResp) && owner_q;
    assign bus.m0_rdata   = rdata0_q;
    assign bus.m1_rdata   = rdata1_q;
    assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: byte-RAM model, vector table, corner sequences, random.
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic init_req = 1'b1;

    dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
    dmem_arbiter #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [31:0] ref_rdata [2];
    logic [7:0]  rb0, rb1, rb2, rb3;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        int          port;
        logic [3:0]  we;
        logic [3:0]  re;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic logic [7:0] pattern(input logic [15:0] a);
        case (a)
            16'h0010: return 8'h11;
            16'h0011: return 8'h22;
            16'h0012: return 8'h33;
            16'h0013: return 8'h44;
            default:  return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // RAM read-extension encoding used by this bench's RAM.
    function automatic logic [31:0] ext(input logic [3:0] re, input logic [7:0] b0,
                                        input logic [7:0] b1, input logic [7:0] b2,
                                        input logic [7:0] b3);
        case (re)
            4'b1111: return {b3, b2, b1, b0};
            4'b0011: return {{16{b1[7]}}, b1, b0};
            4'b1011: return {16'h0000, b1, b0};
            4'b0001: return {{24{b0[7]}}, b0};
            4'b1001: return {24'h000000, b0};
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (init_req) begin
            for (int a = 0; a < 65536; a++) mem[a] <= pattern(16'(a));
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (bus.ram_we[i]) mem[bus.ram_w_addr + 16'(i)] <= bus.ram_w_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        rb0 = mem[bus.ram_r_addr];
        rb1 = mem[bus.ram_r_addr + 16'd1];
        rb2 = mem[bus.ram_r_addr + 16'd2];
        rb3 = mem[bus.ram_r_addr + 16'd3];
        bus.ram_r_data = ext(bus.ram_re, rb0, rb1, rb2, rb3);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Transaction-level reference: write lanes land first, then the read sees the new bytes.
    task automatic model_apply(input int port, input logic [3:0] we, input logic [3:0] re,
                               input logic [15:0] addr, input logic [31:0] wdata);
        for (int i = 0; i < 4; i++) begin
            if (we[i]) ref_mem[addr + 16'(i)] = wdata[8*i +: 8];
        end
        if (re != 4'b0000) begin
            ref_rdata[port] = ext(re, ref_mem[addr], ref_mem[addr + 16'd1],
                                  ref_mem[addr + 16'd2], ref_mem[addr + 16'd3]);
        end
    endtask

    task automatic set_cmd(input int port, input logic req, input logic [3:0] we,
                           input logic [3:0] re, input logic [15:0] addr,
                           input logic [31:0] wdata);
        if (port == 0) begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_re = re;
            bus.m0_addr = addr; bus.m0_wdata = wdata;
        end else begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_re = re;
            bus.m1_addr = addr; bus.m1_wdata = wdata;
        end
    endtask

    function automatic logic ack_of(input int port);
        return (port == 0) ? bus.m0_ack : bus.m1_ack;
    endfunction

    task automatic wait_ack(input int port, input int maxc, output int cyc);
        cyc = 0;
        for (int n = 1; n <= maxc; n++) begin
            @(posedge clk); #1;
            if (ack_of(port)) begin
                cyc = n;
                break;
            end
        end
    endtask

    // Starts from IDLE, ends one cycle after the ack (back in IDLE).
    task automatic do_txn(input string name, input int port, input logic [3:0] we,
                          input logic [3:0] re, input logic [15:0] addr,
                          input logic [31:0] wdata, output logic [31:0] got);
        int   lat;
        logic other_ack;
        logic busy_seen;
        logic [3:0] we_seen;
        lat = 0; other_ack = 1'b0; busy_seen = 1'b0; we_seen = 4'b0000;
        set_cmd(port, 1'b1, we, re, addr, wdata);
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                we_seen   = bus.ram_we;
                busy_seen = bus.busy;
            end
            if (ack_of(1 - port)) other_ack = 1'b1;
            if (ack_of(port)) begin
                lat = n;
                break;
            end
        end
        got = (port == 0) ? bus.m0_rdata : bus.m1_rdata;
        set_cmd(port, 1'b0, 4'b0000, 4'b0000, 16'h0000, 32'h0);
        chk({name, "_lat"}, 32'(lat), 32'd2);
        chk({name, "_ramwe"}, 32'(we_seen), 32'(we));
        chk({name, "_busy"}, 32'(busy_seen), 32'd1);
        chk({name, "_otherack"}, 32'(other_ack), 32'd0);
        model_apply(port, we, re, addr, wdata);
        @(posedge clk); #1;
    endtask

    vec_t        vecs[$];
    logic [31:0] got;
    logic [3:0]  re_list [6] = '{4'b0000, 4'b1111, 4'b0011, 4'b1011, 4'b0001, 4'b1001};
    int          c0, c1;

    initial begin
        set_cmd(0, 1'b0, 4'b0000, 4'b0000, 16'h0000, 32'h0);
        set_cmd(1, 1'b0, 4'b0000, 4'b0000, 16'h0000, 32'h0);
        for (int a = 0; a < 65536; a++) ref_mem[a] = pattern(16'(a));
        ref_rdata[0] = 32'h0;
        ref_rdata[1] = 32'h0;
        #1 rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        init_req = 1'b0;

        chk("rst_busy",   32'(bus.busy),   32'd0);
        chk("rst_m0_ack", 32'(bus.m0_ack), 32'd0);
        chk("rst_m1_ack", 32'(bus.m1_ack), 32'd0);
        chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
        chk("rst_ram_re", 32'(bus.ram_re), 32'd0);
        chk("rst_m0_rdata", bus.m0_rdata, 32'h0);
        chk("rst_m1_rdata", bus.m1_rdata, 32'h0);
        chk("rst_wdata", bus.ram_w_data, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        vecs.push_back('{"rd_word_m0",   0, 4'b0000, 4'b1111, 16'h0010, 32'h0, 32'h44332211});
        vecs.push_back('{"wr_byte_m1",   1, 4'b0001, 4'b0000, 16'h0020, 32'hAB, 32'h0});
        vecs.push_back('{"rd_sbyte_m1",  1, 4'b0000, 4'b0001, 16'h0020, 32'h0, 32'hFFFFFFAB});
        vecs.push_back('{"rd_neigh_m1",  1, 4'b0000, 4'b1111, 16'h0020, 32'h0, 32'h79787BAB});
        vecs.push_back('{"wr_word_m0",   0, 4'b1111, 4'b0000, 16'h0030, 32'hCAFEF00D,
                         32'h44332211});
        vecs.push_back('{"rd_shalf_m0",  0, 4'b0000, 4'b0011, 16'h0030, 32'h0, 32'hFFFFF00D});
        vecs.push_back('{"rd_zhalf_m0",  0, 4'b0000, 4'b1011, 16'h0032, 32'h0, 32'h0000CAFE});
        vecs.push_back('{"nop_m1",       1, 4'b0000, 4'b0000, 16'h0030, 32'h1234, 32'h79787BAB});
        vecs.push_back('{"rd_zbyte_m1",  1, 4'b0000, 4'b1001, 16'h0033, 32'h0, 32'h000000CA});
        vecs.push_back('{"rd_pbyte_m0",  0, 4'b0000, 4'b0001, 16'h0021, 32'h0, 32'h0000007B});
        foreach (vecs[i]) begin
            do_txn(vecs[i].name, vecs[i].port, vecs[i].we, vecs[i].re, vecs[i].addr,
                   vecs[i].wdata, got);
            chk(vecs[i].name, got, vecs[i].exp_rdata);
        end

        // m1 raises req during the m0 RESP cycle and is granted after the following IDLE.
        set_cmd(0, 1'b1, 4'b0000, 4'b1111, 16'h0010, 32'h0);
        wait_ack(0, 10, c0);
        chk("hold_m0_lat", 32'(c0), 32'd2);
        set_cmd(0, 1'b0, 4'b0000, 4'b0000, 16'h0000, 32'h0);
        set_cmd(1, 1'b1, 4'b0000, 4'b1111, 16'h0030, 32'h0);
        wait_ack(1, 10, c1);
        chk("hold_m1_gap", 32'(c1), 32'd3);
        set_cmd(1, 1'b0, 4'b0000, 4'b0000, 16'h0000, 32'h0);
        model_apply(0, 4'b0000, 4'b1111, 16'h0010, 32'h0);
        model_apply(1, 4'b0000, 4'b1111, 16'h0030, 32'h0);
        chk("hold_m0_rdata", bus.m0_rdata, 32'h44332211);
        chk("hold_m1_rdata", bus.m1_rdata, 32'hCAFEF00D);
        @(posedge clk); #1;

        // Contention: both masters hold req with a stable command.
        begin
            int who[$];
            int when[$];
            int exp_who[$];
            int n_exp;
`ifdef DMEM_ARB_RR_EN
            exp_who = '{0, 1, 0, 1};
`else
            exp_who = '{0, 0, 0, 0, 1};
`endif
            n_exp = exp_who.size();
            set_cmd(0, 1'b1, 4'b0000, 4'b1111, 16'h0010, 32'h0);
            set_cmd(1, 1'b1, 4'b0000, 4'b1111, 16'h0020, 32'h0);
            for (int c = 1; c <= 40 && who.size() < n_exp; c++) begin
                @(posedge clk); #1;
                if (bus.m0_ack || bus.m1_ack) begin
                    who.push_back(bus.m1_ack ? 1 : 0);
                    when.push_back(c);
                    if (who.size() == 4) bus.m0_req = 1'b0;
                    if (who.size() == n_exp) begin
                        bus.m0_req = 1'b0;
                        bus.m1_req = 1'b0;
                    end
                end
            end
            bus.m0_req = 1'b0;
            bus.m1_req = 1'b0;
            chk("cont_count", 32'(who.size()), 32'(n_exp));
            for (int k = 0; k < n_exp && k < who.size(); k++) begin
                chk($sformatf("cont_who%0d", k), 32'(who[k]), 32'(exp_who[k]));
                chk($sformatf("cont_when%0d", k), 32'(when[k]), 32'(2 + 3 * k));
            end
            model_apply(0, 4'b0000, 4'b1111, 16'h0010, 32'h0);
            model_apply(1, 4'b0000, 4'b1111, 16'h0020, 32'h0);
            chk("cont_m0_rdata", bus.m0_rdata, ref_rdata[0]);
            chk("cont_m1_rdata", bus.m1_rdata, ref_rdata[1]);
            @(posedge clk); #1;
        end

        for (int t = 0; t < 40; t++) begin
            int          port;
            logic [3:0]  we;
            logic [3:0]  re;
            logic [15:0] addr;
            logic [31:0] wdata;
            port  = int'($urandom_range(0, 1));
            we    = 4'($urandom_range(0, 15));
            re    = re_list[$urandom_range(0, 5)];
            addr  = 16'h0100 + 16'($urandom_range(0, 252));
            wdata = $urandom;
            do_txn($sformatf("rnd%0d", t), port, we, re, addr, wdata, got);
            chk($sformatf("rnd%0d_rdata", t), got, ref_rdata[port]);
        end

        begin
            int bad = 0;
            for (int a = 16'h0100; a < 16'h0200; a++) if (mem[a] !== ref_mem[a]) bad++;
            chk("mem_region", 32'(bad), 32'd0);
        end

        // Reset asserted mid-ACCESS, before the write's falling edge.
        begin
            int acks = 0;
            set_cmd(0, 1'b1, 4'b1111, 4'b0000, 16'h0040, 32'hDEADBEEF);
            @(posedge clk); #1;
            chk("rsta_ram_we_pre", 32'(bus.ram_we), 32'hF);
            rst = 1'b1;
            #1;
            chk("rsta_busy", 32'(bus.busy), 32'd0);
            chk("rsta_ram_we", 32'(bus.ram_we), 32'd0);
            set_cmd(0, 1'b0, 4'b0000, 4'b0000, 16'h0000, 32'h0);
            for (int n = 0; n < 5; n++) begin
                @(posedge clk); #1;
                if (n == 1) rst = 1'b0;
                if (bus.m0_ack || bus.m1_ack) acks++;
            end
            chk("rsta_no_ack", 32'(acks), 32'd0);
            chk("rsta_mem", {mem[16'h43], mem[16'h42], mem[16'h41], mem[16'h40]},
                {ref_mem[16'h43], ref_mem[16'h42], ref_mem[16'h41], ref_mem[16'h40]});
            ref_rdata[0] = 32'h0;
            ref_rdata[1] = 32'h0;
            chk("rsta_m0_rdata", bus.m0_rdata, ref_rdata[0]);
            chk("rsta_m1_rdata", bus.m1_rdata, ref_rdata[1]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter and sequencer for the byte-addressed data RAM. Port 0 serves the CPU load/store unit; port 1 serves the program loader and debug port. Each port uses a req/ack handshake. The arbiter latches the winning command, drives the RAM's byte-lane write and read enables for exactly one access cycle, captures the read data, and returns it with a one-cycle ack pulse. The block sits between both masters and the RAM; no other block drives the RAM ports.

## Interface
- `ADDR_W`, 16: byte-address width presented to the RAM.
- `clk` in 1: single clock, rising edge. The RAM writes on the falling edge of the same clock.
- `rst` in 1: asynchronous, active-high reset.
- `m0_req`, `m1_req` in 1: request. Held high, with the command stable, until the matching ack.
- `m0_we`, `m1_we` in 4: byte-lane write enables.
- `m0_re`, `m1_re` in 4: byte-lane read enables. These follow the RAM's sign/zero-extension encoding.
- `m0_addr`, `m1_addr` in ADDR_W: byte address.
- `m0_wdata`, `m1_wdata` in 32: write data.
- `m0_ack`, `m1_ack` out 1: one-cycle completion pulse.
- `m0_rdata`, `m1_rdata` out 32: registered read data.
- `ram_we`, `ram_re` out 4: to RAM.
- `ram_w_addr`, `ram_r_addr` out ADDR_W: to RAM.
- `ram_w_data` out 32: to RAM.
- `ram_r_data` in 32: from RAM. Combinational with respect to `ram_r_addr`/`ram_re`.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - ACCESS: drive RAM for one cycle.
  - RESP: pulse ack.
  - Reset state is IDLE.
- **IDLE**
  - If any req is high, select a winner and latch its `we`, `re`, `addr`, `wdata` into command registers. Record `owner`, then go to ACCESS.
  - With no req, stay in IDLE.
- **ACCESS**
  - `ram_we`/`ram_re` equal the latched masks. Both RAM address outputs equal the latched address. `ram_w_data` equals the latched wdata.
  - At the closing rising edge, if the latched `re` is nonzero, `ram_r_data` is captured into `owner`'s rdata register.
  - Then go to RESP.
- **RESP**
  - `owner`'s ack is high for this cycle only. Go to IDLE unconditionally.
  - The acked master's req must not be treated as a new request during RESP.
- Outside ACCESS:
  - `ram_we` and `ram_re` are 0. This is decoded combinationally from the state.
  - RAM addresses and wdata hold the latched values.
- `mN_rdata` holds its value until the next read for that master completes. Writes (`re`=0) leave it unchanged.
- A command with both `we`=0 and `re`=0 is still sequenced and acked. No RAM effect.
- Arbitration is governed by `last_grant`, a 1-bit register updated on every grant.
- Reset values:
  - All acks 0, `busy` 0.
  - `ram_we`/`ram_re` 0.
  - Command registers, `mN_rdata` and `ram_w_data` all 0.
  - `owner` 0, `last_grant` 1, so port 0 wins the first contest.
- Reset mid-operation: assertion during ACCESS forces `ram_we` to 0 immediately, so the pending negedge write is suppressed. No ack is issued. The dropped transaction is not replayed; the master re-requests after reset.

## Timing
- req sampled high at rising edge k (state IDLE) → ACCESS during cycle k+1 → ack high during cycle k+2 with rdata valid.
- Write lands on the falling edge inside the ACCESS cycle.
- Throughput: one transaction per 3 cycles. IDLE→ACCESS→RESP→IDLE.
- Back-to-back requests from the same master: its next command is accepted at the edge ending the IDLE cycle that follows RESP. The gap between acks is 3 cycles.
- A req that rises while `busy` is high waits. It is never lost as long as it is held.

## Configuration
- `DMEM_ARB_RR_EN` defined:
  - Round-robin. With both req high in IDLE, the winner is the port not equal to `last_grant`.
  - A single requester always wins regardless of `last_grant`.
- Undefined: fixed priority. Port 0 always wins a contest. `last_grant` is still updated but does not affect selection.

## Test plan
- **Single read:** reset, RAM byte 0x0010..0x0013 = 0x44332211; m0 read `re`=1111 `addr`=0x0010 → `m0_ack` at cycle k+2, `m0_rdata`=0x44332211, `m1_ack` stays 0.
- **Byte write:** m1 write `we`=0001 `addr`=0x0020 `wdata`=0x000000AB, then m1 read `re`=0001 → `m1_rdata`=0xFFFFFFAB (sign-extended by RAM). The neighbouring bytes 0x0021..0x0023 are unchanged.
- **Contention, `DMEM_ARB_RR_EN` defined:** m0 and m1 both hold req continuously for 4 transactions → grants alternate m0,m1,m0,m1, with acks spaced 3 cycles apart.
- **Contention, `DMEM_ARB_RR_EN` undefined:** same stimulus → m0 acked every 3 cycles; m1 acked only after m0 drops req.
- **Reset during ACCESS:** m0 write `we`=1111 `wdata`=0xDEADBEEF to 0x0040; assert `rst` before the ACCESS falling edge → RAM at 0x0040 unchanged, no ack, `busy`=0 immediately.
- **Hold stability:** m1 req rises during an m0 RESP cycle → m1 is granted at the next IDLE edge. `m0_rdata` keeps its previous value across the m1 transaction.
